button_conditioner: RTL and testbench

- Conditions the two raw front-panel buttons (up, down) before they reach the PWM stage.
- Per button: 2-flop synchronizer, counter-based debouncer, single-cycle press pulse, and hold-to-repeat auto-pulses.
- Mutual-exclusion lockout stops contradictory up/down steps.
- Sits directly upstream of the pwm instance in top. The conditioned pulses drive pwm's up/down inputs in place of the raw pins.

---
 rtl/button_conditioner.sv | 189 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Front-panel up/down conditioner: 2-flop sync, counter debounce, press and hold-to-repeat pulses, mutual lockout.
// A clean step sets the level DEBOUNCE_CYCLES+1 edges after first being sampled; the press pulse follows one edge later.

module button_conditioner_chan #(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int HOLD_CYCLES     = 13500000,
   parameter int REPEAT_CYCLES   = 2700000,
   parameter int CNT_W           = 24
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   input  logic i_other_level,
   input  logic i_other_level_d,
   output logic o_level,
   output logic o_level_d,
   output logic o_pulse
);

   localparam logic             L_INV     = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_HD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_dcnt;
   logic [CNT_W-1:0] r_hcnt;
   logic [1:0]       r_state;
   logic             r_pulse;
   logic             w_rise;
   logic             w_other_rise;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw ^ L_INV;
         r_s2 <= r_s1;
      end
   end

   // Any sample that agrees with the current level restarts the count, so bounces never accumulate.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_dcnt    <= '0;
      end else begin
         r_level_d <= r_level;
         if (r_s2 == r_level) begin
            r_dcnt <= '0;
         end else if (r_dcnt == L_DB_LAST) begin
            r_level <= r_s2;
            r_dcnt  <= '0;
         end else begin
            r_dcnt <= r_dcnt + L_ONE;
         end
      end
   end

   assign w_rise       = r_level & ~r_level_d;
   assign w_other_rise = i_other_level & ~i_other_level_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_hcnt  <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  if (i_other_level) begin
                     r_state <= S_LOCKED;
                  end else begin
                     r_pulse <= 1'b1;
                     r_state <= S_HOLD;
                     r_hcnt  <= L_HD_LAST;
                  end
               end
            end
            S_HOLD, S_REPEAT: begin
               // Release wins over an expiring counter so letting go never emits a late step.
               if (!r_level) begin
                  r_state <= S_IDLE;
                  r_hcnt  <= '0;
               end else if (w_other_rise) begin
                  r_state <= S_LOCKED;
                  r_hcnt  <= '0;
               end else if (r_hcnt == '0) begin
                  r_pulse <= 1'b1;
                  r_state <= S_REPEAT;
                  r_hcnt  <= L_RP_LAST;
               end else begin
                  r_hcnt <= r_hcnt - L_ONE;
               end
            end
            S_LOCKED: begin
               if (!r_level) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_hcnt  <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_level_d = r_level_d;
   assign o_pulse   = r_pulse;

endmodule

module button_conditioner #(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int HOLD_CYCLES     = 13500000,
   parameter int REPEAT_CYCLES   = 2700000,
   parameter int CNT_W           = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic up_raw,
   input  logic down_raw,
   output logic up_pulse,
   output logic down_pulse,
   output logic up_level,
   output logic down_level
);

   logic w_up_level;
   logic w_up_level_d;
   logic w_dn_level;
   logic w_dn_level_d;

   // Each channel watches the other's level and rising edge to enforce the lockout.
   button_conditioner_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W)
   ) u_up (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_raw           (up_raw),
      .i_other_level   (w_dn_level),
      .i_other_level_d (w_dn_level_d),
      .o_level         (w_up_level),
      .o_level_d       (w_up_level_d),
      .o_pulse         (up_pulse)
   );

   button_conditioner_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W)
   ) u_down (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_raw           (down_raw),
      .i_other_level   (w_up_level),
      .i_other_level_d (w_up_level_d),
      .o_level         (w_dn_level),
      .o_level_d       (w_dn_level_d),
      .o_pulse         (down_pulse)
   );

   assign up_level   = w_up_level;
   assign down_level = w_dn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, hand-written corner sequences and a randomized run vs a reference model.

module tb_button_conditioner;

   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;
   localparam int NCYC = 80;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic up_raw = 1'b1;
   logic down_raw = 1'b1;
   logic up_pulse, down_pulse, up_level, down_level;

   int total = 0;
   int bad = 0;

   button_conditioner #(
      .ACTIVE_LOW      (1),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP),
      .CNT_W           (24)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up_raw     (up_raw),
      .down_raw   (down_raw),
      .up_pulse   (up_pulse),
      .down_pulse (down_pulse),
      .up_level   (up_level),
      .down_level (down_level)
   );

   always #5 clk = ~clk;

   // Reference model: per-edge history of pressed samples and debounced levels.
   bit m_ru[$];
   bit m_rd[$];
   bit m_lu[$];
   bit m_ld[$];
   int m_n;
   bit m_arm_u, m_arm_d;
   int m_p_u, m_p_d;

   typedef struct {
      int          up_on;
      int          up_off;
      int          dn_on;
      int          dn_off;
      logic [79:0] up_pm;
      logic [79:0] dn_pm;
      int          up_lv_on;
      int          up_lv_off;
      int          dn_lv_on;
      int          dn_lv_off;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, m_n, act, exp);
      end
   endtask

   function automatic bit hist(input bit q[$], input int i);
      return (i < 0) ? 1'b0 : q[i];
   endfunction

   // Level flips once the last DB synchronized samples (raw delayed by two edges) all disagree with it.
   function automatic bit next_level(input bit rq[$], input bit lq[$], input int n);
      bit old;
      bit flip;
      old  = hist(lq, n - 1);
      flip = 1'b1;
      for (int k = n - DB - 1; k <= n - 2; k++)
         if (hist(rq, k) == old) flip = 1'b0;
      return flip ? !old : old;
   endfunction

   // Pulse at press P, then P+HOLD, then every REP, while held and not disturbed by the other button.
   task automatic model_pulse(input bit own[$], input bit oth[$], input int n,
                              inout bit armed, inout int p, output bit pulse);
      bit o1, o2, t1, t2;
      int d;
      o1 = hist(own, n - 1);
      o2 = hist(own, n - 2);
      t1 = hist(oth, n - 1);
      t2 = hist(oth, n - 2);
      pulse = 1'b0;
      if (armed) begin
         if (!o1 || (t1 && !t2)) begin
            armed = 1'b0;
         end else begin
            d = n - p;
            if (d == HOLD || (d > HOLD && ((d - HOLD) % REP) == 0)) pulse = 1'b1;
         end
      end else if (o1 && !o2 && !t1) begin
         pulse = 1'b1;
         armed = 1'b1;
         p     = n;
      end
   endtask

   task automatic model_reset();
      m_ru.delete();
      m_rd.delete();
      m_lu.delete();
      m_ld.delete();
      m_n = 0;
      m_arm_u = 1'b0;
      m_arm_d = 1'b0;
      m_p_u = 0;
      m_p_d = 0;
   endtask

   task automatic step(input bit up_p, input bit dn_p);
      bit pu, pd, lu, ld;
      up_raw   = ~up_p;
      down_raw = ~dn_p;
      m_ru.push_back(up_p);
      m_rd.push_back(dn_p);
      model_pulse(m_lu, m_ld, m_n, m_arm_u, m_p_u, pu);
      model_pulse(m_ld, m_lu, m_n, m_arm_d, m_p_d, pd);
      lu = next_level(m_ru, m_lu, m_n);
      ld = next_level(m_rd, m_ld, m_n);
      m_lu.push_back(lu);
      m_ld.push_back(ld);
      @(posedge clk);
      #1;
      chk("model", 32'({up_level, down_level, up_pulse, down_pulse}), 32'({lu, ld, pu, pd}));
      chk("excl", 32'(up_pulse & down_pulse), 32'd0);
      m_n++;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      up_raw   = 1'b1;
      down_raw = 1'b1;
      #1;
      chk("rst_out", 32'({up_level, down_level, up_pulse, down_pulse}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", 32'({up_level, down_level, up_pulse, down_pulse}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic vec_t mk(input int uon, input int uoff, input int don, input int doff,
                               input logic [79:0] upm, input logic [79:0] dpm,
                               input int ulon, input int uloff, input int dlon, input int dloff);
      vec_t v;
      v.up_on = uon;      v.up_off = uoff;     v.dn_on = don;      v.dn_off = doff;
      v.up_pm = upm;      v.dn_pm = dpm;
      v.up_lv_on = ulon;  v.up_lv_off = uloff; v.dn_lv_on = dlon;  v.dn_lv_off = dloff;
      return v;
   endfunction

   initial begin
      logic [79:0] z;
      logic [79:0] one;
      int hi;
      int up_left, dn_left;
      bit up_v, dn_v;
      bit up_p, dn_p;

      z   = '0;
      one = 80'd1;
      // Clean up press; long down hold with repeats; simultaneous press; up held with down interfering; down held then up pressed.
      tbl[0] = mk(0, 10, -1, -1, one << 6, z, 5, 15, -1, -1);
      tbl[1] = mk(-1, -1, 0, 60, z,
                  (one << 6) | (one << 26) | (one << 34) | (one << 42) | (one << 50) | (one << 58),
                  -1, -1, 5, 65);
      tbl[2] = mk(0, 50, 0, 50, z, z, 5, 55, 5, 55);
      tbl[3] = mk(0, 70, 10, 20, one << 6, z, 5, 75, 15, 25);
      tbl[4] = mk(3, 50, 0, 30, z, one << 6, 8, 55, 5, 35);

      model_reset();
      for (int r = 0; r < 5; r++) begin
         do_reset();
         for (int n = 0; n < NCYC; n++) begin
            up_p = (n >= tbl[r].up_on) && (n < tbl[r].up_off);
            dn_p = (n >= tbl[r].dn_on) && (n < tbl[r].dn_off);
            step(up_p, dn_p);
            chk($sformatf("tbl%0d", r),
                32'({up_level, down_level, up_pulse, down_pulse}),
                32'({(n >= tbl[r].up_lv_on) && (n < tbl[r].up_lv_off),
                     (n >= tbl[r].dn_lv_on) && (n < tbl[r].dn_lv_off),
                     tbl[r].up_pm[n], tbl[r].dn_pm[n]}));
         end
      end

      // Bounce: 3 pressed, 1 released, 3 pressed, then released.
      do_reset();
      hi = 0;
      for (int i = 0; i < 27; i++) begin
         step((i < 3) || (i >= 4 && i < 7), 1'b0);
         hi += int'(up_level | up_pulse);
      end
      chk("bounce", 32'(hi), 32'd0);

      // Lockout then release and re-press of up.
      do_reset();
      for (int n = 0; n < NCYC; n++) begin
         step((n < 40) || (n >= 50 && n < 70), (n >= 10) && (n < 20));
         chk("lock_up", 32'(up_pulse), 32'((n == 6) || (n == 56)));
         chk("lock_dn", 32'(down_pulse), 32'd0);
      end

      // Reset asserted mid-repeat with up still held.
      do_reset();
      for (int n = 0; n <= 30; n++) begin
         step(1'b1, 1'b0);
         chk("pre_rst", 32'(up_pulse), 32'((n == 6) || (n == 26)));
      end
      chk("pre_rst_lvl", 32'(up_level), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async", 32'({up_level, down_level, up_pulse, down_pulse}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_quiet", 32'({up_level, down_level, up_pulse, down_pulse}), 32'd0);
      end
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 30; n++) begin
         step(1'b1, 1'b0);
         chk("post_rst", 32'(up_pulse), 32'((n == 6) || (n == 26)));
         chk("post_rst_lvl", 32'(up_level), 32'(n >= 5));
      end

      // Randomized: mostly short bounces, sometimes long holds that reach repeats.
      do_reset();
      up_v = 1'b0;
      dn_v = 1'b0;
      up_left = 0;
      dn_left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (up_left == 0) begin
            up_v    = ~up_v;
            up_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90)) : int'($urandom_range(1, 8));
         end
         if (dn_left == 0) begin
            dn_v    = ~dn_v;
            dn_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90)) : int'($urandom_range(1, 8));
         end
         up_left--;
         dn_left--;
         step(up_v, dn_v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
